// File: rtl/seq_shift_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_shift_pkg
//   Shared definitions for the multi-cycle shift/rotate engine:
//   - shift_sel op codes (same encoding as the single-step ALU shifter)
//   - FSM state encoding for seq_shift_unit
// -----------------------------------------------------------------------------
package alu_shift_pkg;

  localparam logic [1:0] SEL_SHR = 2'b00;
  localparam logic [1:0] SEL_SHL = 2'b01;
  localparam logic [1:0] SEL_ROR = 2'b10;
  localparam logic [1:0] SEL_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : alu_shift_pkg

// File: rtl/seq_shift_unit_if.sv
// -----------------------------------------------------------------------------
// seq_shift_unit_if
//   Request/response bundle of the shift/rotate engine.
//   Request side : in_valid, in_ready, A, shift_sel, shift_amt
//   Response side: out_valid, out_ready, result
//   Status       : busy
//   modport master : the ALU sequencer (drives requests, consumes results)
//   modport slave  : the shift engine
// -----------------------------------------------------------------------------
interface seq_shift_unit_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [1:0]       shift_sel;
  logic [AMT_W-1:0] shift_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, A, shift_sel, shift_amt, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, A, shift_sel, shift_amt, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface : seq_shift_unit_if

// File: rtl/seq_shift_unit_shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational one-position shift/rotate.
//   d   in  WIDTH  operand
//   sel in  2      SHR / SHL / ROR / ROL (alu_shift_pkg encoding)
//   q   out WIDTH  d moved by one bit position; shifts zero-fill
// -----------------------------------------------------------------------------
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    case (sel)
      SEL_SHR: q = {1'b0, d[WIDTH-1:1]};
      SEL_SHL: q = {d[WIDTH-2:0], 1'b0};
      SEL_ROR: q = {d[0], d[WIDTH-1:1]};
      SEL_ROL: q = {d[WIDTH-2:0], d[WIDTH-1]};
      default: q = d;
    endcase
  end

endmodule : shift_step

// File: rtl/seq_shift_unit.sv
// -----------------------------------------------------------------------------
// seq_shift_unit
//   Multi-cycle shift/rotate engine: moves the operand one bit position per
//   clock, for 0..WIDTH-1 positions, behind valid/ready handshakes.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous reset, active low
//   bus    slave modport of seq_shift_unit_if:
//            in_valid/in_ready/A/shift_sel/shift_amt  request
//            out_valid/out_ready/result               response
//            busy                                     high in SHIFT or DONE
//   A result is available shift_amt+1 cycles after accept and is held
//   until the consumer takes it; only one op is in flight at a time.
// -----------------------------------------------------------------------------
module seq_shift_unit
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_shift_unit_if.slave   bus
);

  localparam int AMT_W = $clog2(WIDTH);

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] step_q;
  logic             accept;
  logic             out_fire;

  assign accept   = bus.in_valid  && (state_q == ST_IDLE);
  assign out_fire = bus.out_ready && (state_q == ST_DONE);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .d   (data_q),
    .sel (op_q),
    .q   (step_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic; cnt_q==1 means this edge performs the final step.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_nxt = (bus.shift_amt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (cnt_q == AMT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_fire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and per-cycle step. Data is reset too so that an
  // aborted op never leaks a partial result onto the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
    end else if (accept) begin
      data_q <= bus.A;
      cnt_q  <= bus.shift_amt;
      op_q   <= bus.shift_sel;
    end else if (state_q == ST_SHIFT) begin
      data_q <= step_q;
      cnt_q  <= cnt_q - AMT_W'(1);
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.result    = data_q;

endmodule : seq_shift_unit

// File: tb/tb_seq_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_unit
//   Directed self-checking bench for seq_shift_unit. Cycle 0 is the cycle in
//   which a request is presented and accepted; latency counts cycles after it.
// -----------------------------------------------------------------------------
module tb_seq_shift_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  seq_shift_unit_if #(.WIDTH(8)) bus ();

  seq_shift_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request from IDLE, then scramble the inputs so any late
  // sampling would corrupt the result. Returns the cycle index in which
  // out_valid was first seen (-1 on timeout) and the result at that point.
  task automatic run_op(input logic [7:0] a, input logic [1:0] sel,
                        input logic [2:0] amt, output int lat,
                        output logic [7:0] res);
    bus.A         = a;
    bus.shift_sel = sel;
    bus.shift_amt = amt;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.A         = ~a;
    bus.shift_sel = ~sel;
    bus.shift_amt = ~amt;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    res = bus.result;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_shr();
    int lat; logic [7:0] res;
    run_op(8'hB4, 2'b00, 3'd3, lat, res);
    checks++; if (lat !== 4) begin errors++; $display("FAIL shr_latency got=%0d exp=4", lat); end
    checks++; if (res !== 8'h16) begin errors++; $display("FAIL shr_result got=%h exp=16", res); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL shr_busy_done got=%b exp=1", bus.busy); end
    take_result();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL shr_in_ready_after got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_shl_rol();
    int lat; logic [7:0] res;
    run_op(8'h81, 2'b01, 3'd1, lat, res);
    checks++; if (lat !== 2) begin errors++; $display("FAIL shl_latency got=%0d exp=2", lat); end
    checks++; if (res !== 8'h02) begin errors++; $display("FAIL shl_result got=%h exp=02", res); end
    take_result();
    run_op(8'h96, 2'b11, 3'd4, lat, res);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rol_latency got=%0d exp=5", lat); end
    checks++; if (res !== 8'h69) begin errors++; $display("FAIL rol_result got=%h exp=69", res); end
    take_result();
  endtask

  task automatic test_ror_and_zero();
    int lat; logic [7:0] res;
    run_op(8'h01, 2'b10, 3'd7, lat, res);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ror7_latency got=%0d exp=8", lat); end
    checks++; if (res !== 8'h02) begin errors++; $display("FAIL ror7_result got=%h exp=02", res); end
    take_result();
    run_op(8'h5A, 2'b00, 3'd0, lat, res);
    checks++; if (lat !== 1) begin errors++; $display("FAIL amt0_latency got=%0d exp=1", lat); end
    checks++; if (res !== 8'h5A) begin errors++; $display("FAIL amt0_result got=%h exp=5A", res); end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] res;
    run_op(8'h0F, 2'b01, 3'd2, lat, res);
    checks++; if (res !== 8'h3C) begin errors++; $display("FAIL bp_result got=%h exp=3C", res); end
    bus.in_valid  = 1'b1;
    bus.A         = 8'hAA;
    bus.shift_sel = 2'b10;
    bus.shift_amt = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.result !== 8'h3C) begin errors++; $display("FAIL bp_hold_result[%0d] got=%h exp=3C", i, bus.result); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", bus.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_not_queued got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.out_ready = 1'b1;
    bus.A         = 8'h03;
    bus.shift_sel = 2'b01;
    bus.shift_amt = 3'd2;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    // Second op stays presented; it can only be taken once the first drains.
    bus.A         = 8'h80;
    bus.shift_sel = 2'b10;
    bus.shift_amt = 3'd1;
    while (!bus.out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL b2b_first_cycle got=%0d exp=3", cyc); end
    checks++; if (bus.result !== 8'h0C) begin errors++; $display("FAIL b2b_first_result got=%h exp=0C", bus.result); end
    @(posedge clk); #1; cyc++;
    while (!bus.out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    bus.in_valid = 1'b0;
    checks++; if (cyc !== 6) begin errors++; $display("FAIL b2b_second_cycle got=%0d exp=6", cyc); end
    checks++; if (bus.result !== 8'h40) begin errors++; $display("FAIL b2b_second_result got=%h exp=40", bus.result); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_after got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [7:0] res;
    bus.A         = 8'hFF;
    bus.shift_sel = 2'b00;
    bus.shift_amt = 3'd6;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", bus.busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL rst_mid_result got=%h exp=00", bus.result); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h96, 2'b11, 3'd4, lat, res);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rst_next_latency got=%0d exp=5", lat); end
    checks++; if (res !== 8'h69) begin errors++; $display("FAIL rst_next_result got=%h exp=69", res); end
    take_result();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = 8'h00;
    bus.shift_sel = 2'b00;
    bus.shift_amt = 3'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_shr();
    test_shl_rol();
    test_ror_and_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_shift_unit
